// File: rtl/aq_djpeg_idctb_ctrl.sv
// aq_djpeg_idctb_ctrl
// Sequencer for the IDCT transpose buffer sitting between the row and column
// passes. The write side turns the first-pass stream into page/count
// addressing and caps resident blocks so the 2-bit bank pointers never alias.
// The read side sweeps the buffer address continuously, corrects the lane
// swap that the buffer applies from its live address, and hands pairs to the
// second pass through a 2-deep valid/ready FIFO.
module aq_djpeg_idctb_ctrl #(
    parameter int MAX_BLOCKS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    output logic        buf_init,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        buf_in_enable,
    output logic [2:0]  buf_in_page,
    output logic [1:0]  buf_in_count,
    input  logic        buf_out_enable,
    output logic        buf_out_read,
    output logic [4:0]  buf_out_address,
    input  logic [15:0] buf_out_a,
    input  logic [15:0] buf_out_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [4:0]  out_addr,
    output logic        out_last,
    output logic [2:0]  occupancy
);

    localparam logic [2:0] MAX_OCC   = 3'(MAX_BLOCKS);
    localparam logic [4:0] LAST_ADDR = 5'd31;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  addr;
        logic        last;
    } entry_t;

    // Sequencing state
    logic [4:0] wr_cnt_r;
    logic [4:0] rd_cnt_r;
    logic [2:0] occ_r;
    logic       inflight_r;
    logic [4:0] inflight_addr_r;

    // Output FIFO: head is the presented pair, tail the one behind it
    entry_t head_r;
    entry_t tail_r;
    logic   head_vld_r;
    logic   tail_vld_r;

    // Per-cycle decisions
    logic       in_ready_s;
    logic       accept_s;
    logic       pop_s;
    logic       room_s;
    logic       issue_s;
    logic       wr_blk_end_s;
    logic       rd_blk_end_s;
    logic       swap_s;
    logic [1:0] pend_s;
    entry_t     cap_s;
    entry_t     head_nxt_s;
    entry_t     tail_nxt_s;
    logic       head_vld_nxt_s;
    logic       tail_vld_nxt_s;

    // Write acceptance, read issue and block-boundary detection
    always_comb begin
        pend_s = {1'b0, head_vld_r} + {1'b0, tail_vld_r} + {1'b0, inflight_r};
        room_s = (pend_s < 2'd2);
        pop_s  = head_vld_r & out_ready;
        if (rst || init) begin
            in_ready_s = 1'b0;
            issue_s    = 1'b0;
        end else begin
            // occupancy only moves at block ends, so a started block always finishes
            in_ready_s = (occ_r < MAX_OCC);
            // a pop this cycle frees the slot the new issue will need two cycles later
            issue_s    = buf_out_enable & (room_s | pop_s);
        end
        accept_s     = in_valid & in_ready_s;
        wr_blk_end_s = accept_s & (wr_cnt_r == LAST_ADDR);
        rd_blk_end_s = issue_s & (rd_cnt_r == LAST_ADDR);
    end

    // Capture of the registered buffer data, undoing the live-address lane swap
    always_comb begin
        swap_s     = inflight_addr_r[4] ^ rd_cnt_r[4];
        cap_s.addr = inflight_addr_r;
        cap_s.last = (inflight_addr_r == LAST_ADDR);
        if (swap_s) begin
            cap_s.a = buf_out_b;
            cap_s.b = buf_out_a;
        end else begin
            cap_s.a = buf_out_a;
            cap_s.b = buf_out_b;
        end
    end

    // Next-state of the 2-entry output FIFO (push comes from the capture stage)
    always_comb begin
        head_nxt_s     = head_r;
        tail_nxt_s     = tail_r;
        head_vld_nxt_s = head_vld_r;
        tail_vld_nxt_s = tail_vld_r;
        if (pop_s) begin
            if (tail_vld_r) begin
                head_nxt_s     = tail_r;
                head_vld_nxt_s = 1'b1;
                tail_nxt_s     = inflight_r ? cap_s : tail_r;
                tail_vld_nxt_s = inflight_r;
            end else begin
                head_nxt_s     = inflight_r ? cap_s : head_r;
                head_vld_nxt_s = inflight_r;
                tail_vld_nxt_s = 1'b0;
            end
        end else if (inflight_r) begin
            if (head_vld_r) begin
                tail_nxt_s     = cap_s;
                tail_vld_nxt_s = 1'b1;
            end else begin
                head_nxt_s     = cap_s;
                head_vld_nxt_s = 1'b1;
            end
        end else begin
            head_vld_nxt_s = head_vld_r;
            tail_vld_nxt_s = tail_vld_r;
        end
    end

    // Write/read counters, block occupancy and the one-cycle capture pipeline
    always_ff @(posedge clk) begin
        if (rst || init) begin
            wr_cnt_r        <= 5'd0;
            rd_cnt_r        <= 5'd0;
            occ_r           <= 3'd0;
            inflight_r      <= 1'b0;
            inflight_addr_r <= 5'd0;
        end else begin
            if (accept_s) begin
                wr_cnt_r <= wr_cnt_r + 5'd1;
            end
            if (issue_s) begin
                rd_cnt_r        <= rd_cnt_r + 5'd1;
                inflight_addr_r <= rd_cnt_r;
            end
            inflight_r <= issue_s;
            case ({wr_blk_end_s, rd_blk_end_s})
                2'b10:   occ_r <= occ_r + 3'd1;
                2'b01:   occ_r <= occ_r - 3'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Output FIFO registers
    always_ff @(posedge clk) begin
        if (rst || init) begin
            head_r     <= '0;
            tail_r     <= '0;
            head_vld_r <= 1'b0;
            tail_vld_r <= 1'b0;
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            head_vld_r <= head_vld_nxt_s;
            tail_vld_r <= tail_vld_nxt_s;
        end
    end

    assign buf_init        = init;
    assign in_ready        = in_ready_s;
    assign buf_in_enable   = accept_s;
    assign buf_in_page     = wr_cnt_r[4:2];
    assign buf_in_count    = wr_cnt_r[1:0];
    assign buf_out_read    = issue_s;
    assign buf_out_address = rd_cnt_r;
    assign out_valid       = head_vld_r;
    assign out_a           = head_r.a;
    assign out_b           = head_r.b;
    assign out_addr        = head_r.addr;
    assign out_last        = head_r.last;
    assign occupancy       = occ_r;

endmodule

// File: tb/tb_aq_djpeg_idctb_ctrl.sv
// Bench for aq_djpeg_idctb_ctrl: a behavioural transpose-buffer model drives
// the read data path; a scoreboard checks every write address, read address,
// delivered pair and occupancy against a queue of written pairs.
module tb_aq_djpeg_idctb_ctrl;

    localparam int MAXB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        buf_init;
    logic        in_valid;
    logic        in_ready;
    logic        buf_in_enable;
    logic [2:0]  buf_in_page;
    logic [1:0]  buf_in_count;
    logic        buf_out_enable;
    logic        buf_out_read;
    logic [4:0]  buf_out_address;
    logic [15:0] buf_out_a;
    logic [15:0] buf_out_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [4:0]  out_addr;
    logic        out_last;
    logic [2:0]  occupancy;

    aq_djpeg_idctb_ctrl #(.MAX_BLOCKS(MAXB)) dut (
        .clk(clk), .rst(rst), .init(init), .buf_init(buf_init),
        .in_valid(in_valid), .in_ready(in_ready), .buf_in_enable(buf_in_enable),
        .buf_in_page(buf_in_page), .buf_in_count(buf_in_count),
        .buf_out_enable(buf_out_enable), .buf_out_read(buf_out_read),
        .buf_out_address(buf_out_address), .buf_out_a(buf_out_a), .buf_out_b(buf_out_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_addr(out_addr), .out_last(out_last), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- transpose buffer model ----------------
    logic [15:0] din_a = 16'd0;
    logic [15:0] din_b = 16'd0;
    logic        en_force = 1'b0;
    logic [15:0] mem_a [0:127];
    logic [15:0] mem_b [0:127];
    logic [1:0]  wbank = 2'd0;
    logic [1:0]  rbank = 2'd0;
    logic [15:0] raw_a = 16'd0;
    logic [15:0] raw_b = 16'd0;
    logic [4:0]  raw_p = 5'd0;

    always @(posedge clk) begin
        if (rst || buf_init) begin
            wbank <= 2'd0;
            rbank <= 2'd0;
        end else begin
            if (buf_in_enable) begin
                mem_a[{wbank, buf_in_page, buf_in_count}] <= din_a;
                mem_b[{wbank, buf_in_page, buf_in_count}] <= din_b;
                if ({buf_in_page, buf_in_count} == 5'd31) wbank <= wbank + 2'd1;
            end
            if (buf_out_read) begin
                raw_a <= mem_a[{rbank, buf_out_address}];
                raw_b <= mem_b[{rbank, buf_out_address}];
                raw_p <= buf_out_address;
                if (buf_out_address == 5'd31) rbank <= rbank + 2'd1;
            end
        end
    end

    // data is registered but the lane order follows the live address half
    assign buf_out_enable = en_force && (wbank != rbank);
    assign buf_out_a = (raw_p[4] == buf_out_address[4]) ? raw_a : raw_b;
    assign buf_out_b = (raw_p[4] == buf_out_address[4]) ? raw_b : raw_a;

    // ---------------- checking infrastructure ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  addr;
    } pair_t;

    pair_t      expq[$];
    logic [4:0] wr_m = 5'd0;
    logic [4:0] rd_m = 5'd0;
    int bw = 0, br = 0, n_rd = 0, n_pop = 0;

    task automatic clr_model();
        wr_m = 5'd0; rd_m = 5'd0;
        bw = 0; br = 0; n_rd = 0; n_pop = 0;
        expq.delete();
    endtask

    // scoreboard: samples 1 time unit before each rising edge
    always @(negedge clk) begin
        pair_t e;
        #4;
        if (rst) begin
            clr_model();
        end else if (init) begin
            chk("init_in_ready", in_ready, 1'b0);
            clr_model();
        end else begin
            chk("in_ready", in_ready, ((bw - br) < MAXB));
            chk("occupancy", occupancy, bw - br);
            chk("buffered_le_2", ((n_rd - n_pop) <= 2), 1'b1);
            if (buf_in_enable) begin
                chk("wr_addr", {buf_in_page, buf_in_count}, wr_m);
                expq.push_back('{din_a, din_b, wr_m});
                if (wr_m == 5'd31) bw++;
                wr_m = wr_m + 5'd1;
            end
            if (buf_out_read) begin
                chk("rd_addr", buf_out_address, rd_m);
                n_rd++;
                if (rd_m == 5'd31) br++;
                rd_m = rd_m + 5'd1;
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (expq.size() == 0) begin
                    chk("out_unexpected", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_addr", out_addr, e.addr);
                    chk("out_last", out_last, (e.addr == 5'd31));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_in(input logic v);
        in_valid = v;
        din_a = 16'($urandom);
        din_b = 16'($urandom);
    endtask

    task automatic write_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_in(1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxcyc);
        in_valid = 1'b0;
        en_force = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < maxcyc; k++) begin
            @(negedge clk);
            if (expq.size() == 0 && n_rd == n_pop) break;
        end
        #1;
        chk("drain_empty", expq.size(), 0);
        chk("drain_occupancy", occupancy, 3'd0);
    endtask

    typedef struct {
        logic       iv;
        logic       ini;
        logic       e_ird;
        logic       e_bie;
        logic [4:0] e_wa;
        logic       e_ov;
        logic [2:0] e_occ;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   cnt;
        int   rd0;
        int   pop0;
        logic found;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 3'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 3'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 3'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 3'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 3'd0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 3'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3'd0};

        rst = 1'b1; init = 1'b0; in_valid = 1'b0; out_ready = 1'b0; en_force = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_buf_in_enable", buf_in_enable, 1'b0);
        chk("rst_buf_out_read", buf_out_read, 1'b0);
        chk("rst_buf_out_address", buf_out_address, 5'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ab", {out_a, out_b}, 32'd0);
        chk("rst_out_addr_last", {out_addr, out_last}, 6'd0);
        chk("rst_occupancy", occupancy, 3'd0);

        // table of single-cycle write/init vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_in(vecs[i].iv);
            init = vecs[i].ini;
            #1;
            chk("vec_in_ready", in_ready, vecs[i].e_ird);
            chk("vec_buf_in_enable", buf_in_enable, vecs[i].e_bie);
            chk("vec_wr_addr", {buf_in_page, buf_in_count}, vecs[i].e_wa);
            chk("vec_out_valid", out_valid, vecs[i].e_ov);
            chk("vec_occupancy", occupancy, vecs[i].e_occ);
        end
        @(negedge clk);
        in_valid = 1'b0; init = 1'b0;

        // one block end to end: latency and 1 pair/clk throughput
        en_force = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive_in(1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("first_issue", buf_out_read, 1'b1);
        chk("first_issue_addr", buf_out_address, 5'd0);
        chk("block_occupancy", occupancy, 3'd1);
        cnt = 1;
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            #1;
            cnt += int'(buf_out_read);
            if (k == 1) chk("latency_no_valid_yet", out_valid, 1'b0);
            if (k == 2) chk("latency_valid_addr0", {out_valid, out_addr}, {1'b1, 5'd0});
        end
        chk("throughput_32", cnt, 32);
        wait_drain(200);

        // full: read side off, 96 pairs accepted then in_ready low
        en_force = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            drive_in(1'b1);
            #1;
            cnt += int'(buf_in_enable);
        end
        chk("full_accepted", cnt, 96);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_occupancy", occupancy, 3'd3);
        chk("full_no_strobe", buf_in_enable, 1'b0);
        wait_drain(400);

        // simultaneous write of 31 and read issue of 31
        en_force = 1'b0;
        write_pairs(63);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            in_valid = 1'b0; en_force = 1'b1; out_ready = 1'b1;
            #1;
            if (buf_out_read && buf_out_address == 5'd31) begin
                found = 1'b1;
                drive_in(1'b1);
                #1;
                chk("sim_bie", buf_in_enable, 1'b1);
                chk("sim_wr_addr", {buf_in_page, buf_in_count}, 5'd31);
                chk("sim_occ_before", occupancy, 3'd1);
            end
        end
        chk("sim_found", found, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("sim_occ_after", occupancy, 3'd1);
        chk("sim_in_ready", in_ready, 1'b1);
        wait_drain(200);

        // out_ready toggling across a block
        en_force = 1'b0;
        write_pairs(32);
        en_force = 1'b1;
        rd0 = n_rd; pop0 = n_pop;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            out_ready = k[0];
            if (n_pop - pop0 >= 32) break;
        end
        repeat (4) @(negedge clk);
        chk("toggle_reads", n_rd - rd0, 32);
        chk("toggle_pops", n_pop - pop0, 32);
        wait_drain(100);

        // init in the middle of a block (wr=10, rd=5)
        en_force = 1'b0;
        write_pairs(42);
        en_force = 1'b1; out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            #1;
            if (buf_out_read && buf_out_address == 5'd4) found = 1'b1;
        end
        chk("init_reach_rd4", found, 1'b1);
        @(negedge clk);
        init = 1'b1;
        #1;
        chk("init_cycle_addr", buf_out_address, 5'd5);
        chk("init_cycle_no_read", buf_out_read, 1'b0);
        chk("init_cycle_wr_addr", {buf_in_page, buf_in_count}, 5'd10);
        @(negedge clk);
        init = 1'b0;
        #1;
        chk("post_init_occ", occupancy, 3'd0);
        chk("post_init_out_valid", out_valid, 1'b0);
        chk("post_init_rd_addr", buf_out_address, 5'd0);
        chk("post_init_wr_addr", {buf_in_page, buf_in_count}, 5'd0);
        write_pairs(32);
        wait_drain(200);

        // randomized traffic against the scoreboard
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            drive_in($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            en_force  = ($urandom_range(0, 4) != 0);
        end
        out_ready = 1'b1; en_force = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (wr_m == 5'd0) break;
            drive_in(1'b1);
        end
        in_valid = 1'b0;
        chk("rand_block_complete", wr_m, 5'd0);
        wait_drain(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aq_djpeg_idctb_ctrl.md
# aq_djpeg_idctb_ctrl

Sequencer for the IDCT transpose buffer between the first (row) and second (column) IDCT passes. It converts the first-pass output stream into buffer write page/count addressing and limits buffer occupancy so the 2-bit bank pointers never alias. It drives the buffer read port with a continuous address sweep and delivers corrected A/B lane pairs to the second pass through a valid/ready interface with backpressure.

## Interface
- MAX_BLOCKS, default 3: maximum blocks resident in the buffer; must be ≤ 3 (4 banks, pointer equality means empty).
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- init  input  1  frame start; synchronous clear of all sequencing state
- buf_init  output  1  = init; drives the buffer DataInit
- in_valid  input  1  first-pass pair valid (A/B data wired directly to buffer)
- in_ready  output  1  pair accepted when in_valid & in_ready
- buf_in_enable  output  1  buffer write strobe
- buf_in_page  output  3  buffer DataInPage
- buf_in_count  output  2  buffer DataInCount
- buf_out_enable  input  1  buffer DataOutEnable (bank available)
- buf_out_read  output  1  buffer DataOutRead
- buf_out_address  output  5  buffer DataOutAddress
- buf_out_a, buf_out_b  input  16 each  buffer DataOutA/B
- out_valid  output  1  second-pass pair valid
- out_ready  input  1  second-pass accept
- out_a, out_b  output  16 each  lane-corrected pair
- out_addr  output  5  buffer address of the delivered pair
- out_last  output  1  out_addr == 31
- occupancy  output  3  blocks written and not fully read

## Operation
- Write side: 5-bit wr_cnt; buf_in_page = wr_cnt[4:2], buf_in_count = wr_cnt[1:0]; buf_in_enable = in_valid & in_ready (combinational). wr_cnt increments per accepted pair and wraps 31→0.
- in_ready = (occupancy < MAX_BLOCKS) & ~init. occupancy changes only at block end, so a started block always completes.
- occupancy: +1 on accepted pair with wr_cnt==31; −1 on read issue with rd_cnt==31; both in the same cycle → unchanged.
- Read side: 5-bit rd_cnt drives buf_out_address. An issue (buf_out_read=1, rd_cnt++) occurs when buf_out_enable & (fifo_cnt + inflight < 2 | out_valid & out_ready). Exactly one buf_out_read per address; the buffer advances its bank on issuing 31.
- buf_out_address holds its value when no issue occurs.
- Capture: buffer data is registered (1-cycle latency), but its lane swap follows the address currently driven. The cycle after an issue of address P, capture {buf_out_a, buf_out_b} and swap the lanes when P[4] != current buf_out_address[4]. Push {a, b, P} into a 2-entry FIFO.
- out_* is the FIFO head. Pop on out_valid & out_ready.
- init or rst: wr_cnt, rd_cnt, occupancy, inflight, FIFO cleared. In-flight capture discarded.

## Timing
- Reset values: in_ready 1 after reset release, buf_in_enable 0, buf_out_read 0, buf_out_address 0, out_valid 0, out_a/out_b/out_addr 0, out_last 0, occupancy 0.
- Write: zero latency; address valid in the same cycle as the strobe.
- Read: issue at cycle t → FIFO push at t+1 → out_valid at t+2 (registered FIFO output).
- With out_ready held high, throughput is 1 pair/clk, and a block drains in 32 consecutive issues.
- out_ready low: at most 2 pairs buffered. Issue stalls; no pair is lost or duplicated.
- Full: occupancy == MAX_BLOCKS → in_ready low until the read side issues address 31.
- Wrap: rd_cnt 31→0 continues into the next bank without a bubble when buf_out_enable stays high the cycle after.
- init mid-block: takes effect at that edge; in_ready low in the init cycle; next accepted pair uses page 0 count 0.

## Test plan
- Reset, then 32 pairs with out_ready=1 → 32 buf_in_enable strobes at page/count 0/0…7/3; occupancy 1; 32 outputs out_addr 0…31, out_last only on 31; occupancy back to 0.
- Write 3 blocks with the read side disabled (buf_out_enable=0) → in_ready drops after pair 96, occupancy=3; a 97th in_valid is not accepted.
- Lane correction: addresses 15→16 and 31→0 transitions → out_a/out_b match the model with no swapped pair.
- out_ready toggling 1/0 every cycle across a block → 32 pairs in order, none dropped or duplicated, buf_out_read count = 32.
- Simultaneous write of address 31 and read issue of address 31 → occupancy unchanged, in_ready stays high.
- init asserted at wr_cnt=10, rd_cnt=5 → next cycle counters, occupancy and out_valid are 0; a fresh block streams correctly.
